// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader_if
// Description : Bundles the FIFO read-port signals and the downstream
//               valid/ready stream of fifo_stream_reader.
//               master : the reader (drives fifo_rd_en, m_valid, m_data)
//               slave  : the environment (FIFO + consumer)
//   fifo_empty  FIFO empty flag (registered inside the FIFO)
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  read strobe into the FIFO
//   m_valid     output word valid
//   m_data      output word
//   m_ready     consumer accepts m_data when m_valid && m_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drain-side companion of the synchronous FIFO. Issues read
//               strobes, absorbs the FIFO's one-cycle registered read latency
//               in a 2-entry skid buffer and presents the words on a
//               valid/ready stream at up to one word per cycle.
// Ports       :
//   clk         single clock, posedge
//   reset       synchronous active-high reset, clears all state
//   clear       synchronous flush (shared with the FIFO), keeps xfer_count
//   bus         fifo_stream_reader_if.master (FIFO read port + stream)
//   xfer_count  number of accepted output words, wraps mod 2^CNT_WIDTH
//   busy        words held or a read outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 clear,
    fifo_stream_reader_if.master      bus,
    output logic [CNT_WIDTH-1:0]      xfer_count,
    output logic                      busy
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]           C_HOLD_MAX = 3'd2;

    // Buffer occupancy doubles as the control state.
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                  r_occ;
    occ_t                  w_occ_next;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [DATA_WIDTH-1:0] w_buf0_next;
    logic [DATA_WIDTH-1:0] w_buf1_next;
    logic [CNT_WIDTH-1:0]  r_xfer;

    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_held;
    logic                  w_rd_en;

    assign w_valid = (r_occ != OCC_0);
    assign w_pop   = w_valid && bus.m_ready;

    // Words held plus the word in flight; the strobe logic keeps this <= 2.
    assign w_held  = {1'b0, r_occ} + {2'b00, r_inflight};

    // A pop this cycle frees a slot, so reading stays legal even when full;
    // this is the only combinational input-to-output path.
    assign w_rd_en = !reset && !clear && !bus.fifo_empty
                     && ((w_held < C_HOLD_MAX) || w_pop);

    // ------------------------------------------------------------------------
    // Next-state: apply this cycle's pop first, then drop the returning word
    // (if any) into the first free slot.
    // ------------------------------------------------------------------------
    always_comb begin
        w_occ_next  = r_occ;
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;

        case (r_occ)
            OCC_0: begin
                if (r_inflight) begin
                    w_buf0_next = bus.fifo_dout;
                    w_occ_next  = OCC_1;
                end
            end
            OCC_1: begin
                if (w_pop && r_inflight) begin
                    w_buf0_next = bus.fifo_dout;
                end else if (w_pop) begin
                    w_occ_next  = OCC_0;
                end else if (r_inflight) begin
                    w_buf1_next = bus.fifo_dout;
                    w_occ_next  = OCC_2;
                end
            end
            OCC_2: begin
                // A read is never outstanding while both slots are held
                // unless a pop was granted, so inflight implies pop here.
                if (w_pop) begin
                    w_buf0_next = r_buf1;
                    if (r_inflight) begin
                        w_buf1_next = bus.fifo_dout;
                    end else begin
                        w_occ_next  = OCC_1;
                    end
                end
            end
            default: begin
                w_occ_next = OCC_0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register: reset > clear > normal operation.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ      <= OCC_0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_xfer     <= '0;
        end else if (clear) begin
            // A word still returning from a pre-clear read is dropped by
            // clearing inflight; the counter keeps its history.
            r_occ      <= OCC_0;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= w_rd_en;
            r_buf0     <= w_buf0_next;
            r_buf1     <= w_buf1_next;
            if (w_pop) begin
                r_xfer <= r_xfer + C_CNT_ONE;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = r_buf0;
    assign xfer_count     = r_xfer;
    assign busy           = w_valid || r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed self-checking bench for fifo_stream_reader with a
//               behavioural registered-read FIFO in front of it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [CW-1:0] xfer_count;
    logic          busy;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .bus        (bus),
        .xfer_count (xfer_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] got[$];
    int cyc = 0;
    int rd_cnt, rd_run, max_rd_run, pop_run, max_pop_run, first_rd, first_val;

    // FIFO model: registered read data and registered empty flag.
    always @(posedge clk) begin
        cyc++;
        if (clear) begin
            fq.delete();
        end else if (bus.fifo_rd_en && fq.size() > 0) begin
            bus.fifo_dout <= fq.pop_front();
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    // Monitor
    always @(negedge clk) begin
        assert (dut.r_occ != 2'd3) else begin
            errors++;
            $display("FAIL occ_bound: occupancy reached 3");
        end
        if (bus.fifo_rd_en) begin
            checks++;
            if (bus.fifo_empty) begin
                errors++;
                $display("FAIL rd_on_empty: fifo_rd_en=1 with fifo_empty=1 at cycle %0d", cyc);
            end
            rd_cnt++;
            rd_run++;
            if (rd_run > max_rd_run) max_rd_run = rd_run;
            if (first_rd < 0) first_rd = cyc;
        end else begin
            rd_run = 0;
        end
        if (!reset && !clear && bus.m_valid && bus.m_ready) begin
            got.push_back(bus.m_data);
            pop_run++;
            if (pop_run > max_pop_run) max_pop_run = pop_run;
        end else begin
            pop_run = 0;
        end
        if (bus.m_valid && first_val < 0) first_val = cyc;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        rd_cnt = 0; rd_run = 0; max_rd_run = 0;
        pop_run = 0; max_pop_run = 0;
        first_rd = -1; first_val = -1;
        got.delete();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(fq.size() == 0 && bus.fifo_empty && !busy) && n < max_cycles) begin
            tick(1);
            n++;
        end
        if (n >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; bus.m_ready = 1'b0;
        tick(2);
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h want 00", bus.m_data); end
        checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", xfer_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rden: got %0b want 0", bus.fifo_rd_en); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        clr_mon();
        fq.push_back(8'hA5);
        wait_idle(20);
        checks++; if (rd_cnt != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", rd_cnt); end
        checks++; if (got.size() != 1) begin errors++; $display("FAIL single_words: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h want a5", got[0]); end
        end
        checks++; if (first_val - first_rd != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", first_val - first_rd); end
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", xfer_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b want 0", busy); end
    endtask

    task automatic test_burst();
        bus.m_ready = 1'b1;
        clr_mon();
        for (int i = 0; i < 8; i++) fq.push_back(8'(i));
        wait_idle(40);
        checks++; if (rd_cnt != 8) begin errors++; $display("FAIL burst_strobes: got %0d want 8", rd_cnt); end
        checks++; if (max_rd_run != 8) begin errors++; $display("FAIL burst_strobe_run: got %0d want 8", max_rd_run); end
        checks++; if (max_pop_run != 8) begin errors++; $display("FAIL burst_valid_run: got %0d want 8", max_pop_run); end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL burst_words: got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL burst_data[%0d]: got %02h want %02h", i, got[i], 8'(i)); end
        end
        checks++; if (xfer_count !== 4'd9) begin errors++; $display("FAIL burst_count: got %0d want 9", xfer_count); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        bus.m_ready = 1'b0;
        clr_mon();
        for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.m_valid && bus.m_data !== 8'h10) bad++;
        end
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL bp_strobes: got %0d want 2", rd_cnt); end
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h10) begin errors++; $display("FAIL bp_hold: got %02h want 10", bus.m_data); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, want 0", bad); end
        bus.m_ready = 1'b1;
        wait_idle(40);
        checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_words: got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %02h want %02h", i, got[i], 8'h10 + 8'(i)); end
        end
        checks++; if (max_pop_run != 8) begin errors++; $display("FAIL bp_no_gaps: run %0d want 8", max_pop_run); end
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL bp_count: got %0d want 1", xfer_count); end
    endtask

    task automatic test_alternating();
        clr_mon();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 30; i++) begin
            bus.m_ready = ~bus.m_ready;
            tick(1);
        end
        bus.m_ready = 1'b1;
        wait_idle(20);
        checks++; if (got.size() != 6) begin errors++; $display("FAIL alt_words: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'h20 + 8'(i)) begin errors++; $display("FAIL alt_data[%0d]: got %02h want %02h", i, got[i], 8'h20 + 8'(i)); end
        end
        checks++; if (xfer_count !== 4'd7) begin errors++; $display("FAIL alt_count: got %0d want 7", xfer_count); end
    endtask

    task automatic test_clear();
        int n;
        pulse_reset();
        clr_mon();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) fq.push_back(8'h30 + 8'(i));
        n = 0;
        while (xfer_count !== 4'd3 && n < 30) begin
            tick(1);
            n++;
        end
        checks++; if (n >= 30) begin errors++; $display("FAIL clr_reach3: count %0d, want 3", xfer_count); end
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %0b want 1", bus.m_valid); end
        clear = 1'b1;
        #1;
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL clr_rden: got %0b want 0", bus.fifo_rd_en); end
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b want 0", bus.m_valid); end
        checks++; if (xfer_count !== 4'd3) begin errors++; $display("FAIL clr_count: got %0d want 3", xfer_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %0b want 0", busy); end
        tick(3);
        checks++; if (got.size() != 3) begin errors++; $display("FAIL clr_words: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL clr_data[%0d]: got %02h want %02h", i, got[i], 8'h30 + 8'(i)); end
        end
        fq.push_back(8'h5A);
        wait_idle(20);
        checks++; if (got.size() != 4) begin errors++; $display("FAIL clr_post_words: got %0d want 4", got.size()); end
        else begin
            checks++; if (got[3] !== 8'h5A) begin errors++; $display("FAIL clr_post_data: got %02h want 5a", got[3]); end
        end
        checks++; if (xfer_count !== 4'd4) begin errors++; $display("FAIL clr_post_count: got %0d want 4", xfer_count); end
    endtask

    task automatic test_wrap_reset();
        int bad;
        bad = 0;
        pulse_reset();
        clr_mon();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) fq.push_back(8'h40 + 8'(i));
        wait_idle(80);
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", xfer_count); end
        checks++; if (got.size() != 17) begin errors++; $display("FAIL wrap_words: got %0d want 17", got.size()); end
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_data[%0d]: got %02h want %02h", i, got[i], 8'h40 + 8'(i)); end
        end
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(8'h60 + 8'(i));
        tick(4);
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b want 1", bus.m_valid); end
        bus.m_ready = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rden: got %0b want 0", bus.fifo_rd_en); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00
                || xfer_count !== 4'd0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_outputs: %0d nonzero cycles, want 0", bad); end
        checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL mid_fifo_kept: fifo_empty %0b want 0", bus.fifo_empty); end
        reset = 1'b0;
        wait_idle(40);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_alternating();
        test_clear();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
